// File: rtl/cmp_minmax_seq.sv
// Sequential min/max finder that time-shares one comparator_4_df1 across a burst.
// Optional macro CMP_ARGIDX_EN adds Max_idx/Min_idx argmax/argmin outputs.

module comparator_4_df1 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       Eq,
    output logic       Gt,
    output logic       St
);
    assign Eq = (A == B);
    assign Gt = (A > B);
    assign St = (A < B);
endmodule

module cmp_minmax_seq #(
    parameter  int N_SAMPLES = 8,
    localparam int CNT_W     = $clog2(N_SAMPLES + 1)
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Start,
    input  logic [3:0] Din,
    input  logic       Din_valid,
    output logic       Din_ready,
    output logic [3:0] Max,
    output logic [3:0] Min,
    output logic       Busy,
    output logic       Done,
    output logic [2:0] state_dbg
`ifdef CMP_ARGIDX_EN
    ,
    output logic [CNT_W-1:0] Max_idx,
    output logic [CNT_W-1:0] Min_idx
`endif
);
    // Handshake: a sample transfers on a rising CLK edge where Din_valid and
    // Din_ready are both 1; Din_ready depends only on state, never on Din_valid.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        WAIT_IN = 3'd2,
        CMP_MAX = 3'd3,
        CMP_MIN = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       sample_q;
    logic [CNT_W-1:0] count_q;
    logic [3:0]       cmp_b;
    logic             cmp_eq, cmp_gt, cmp_st;
    logic             upd_max, upd_min, last_sample;

    comparator_4_df1 u_cmp (
        .A  (sample_q),
        .B  (cmp_b),
        .Eq (cmp_eq),
        .Gt (cmp_gt),
        .St (cmp_st)
    );

    // Strict compares only: an equal sample never displaces the stored extreme.
    assign upd_max     = cmp_gt && !cmp_eq;
    assign upd_min     = cmp_st && !cmp_eq;
    assign last_sample = ((int'(count_q) + 1) == N_SAMPLES);
    assign state_dbg   = state;

    always_comb begin
        state_nxt = state;
        Din_ready = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        cmp_b     = Max;
        case (state)
            IDLE: begin
                if (Start) state_nxt = LOAD;
            end
            LOAD: begin
                Din_ready = 1'b1;
                Busy      = 1'b1;
                if (Din_valid) state_nxt = (N_SAMPLES == 1) ? DONE : WAIT_IN;
            end
            WAIT_IN: begin
                Din_ready = 1'b1;
                Busy      = 1'b1;
                if (Din_valid) state_nxt = CMP_MAX;
            end
            CMP_MAX: begin
                Busy      = 1'b1;
                cmp_b     = Max;
                state_nxt = CMP_MIN;
            end
            CMP_MIN: begin
                Busy      = 1'b1;
                cmp_b     = Min;
                state_nxt = last_sample ? DONE : WAIT_IN;
            end
            DONE: begin
                Done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            Max      <= 4'd0;
            Min      <= 4'd0;
            sample_q <= 4'd0;
            count_q  <= '0;
`ifdef CMP_ARGIDX_EN
            Max_idx  <= '0;
            Min_idx  <= '0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                LOAD: begin
                    if (Din_valid) begin
                        Max     <= Din;
                        Min     <= Din;
                        count_q <= CNT_W'(1);
`ifdef CMP_ARGIDX_EN
                        Max_idx <= '0;
                        Min_idx <= '0;
`endif
                    end
                end
                WAIT_IN: begin
                    if (Din_valid) sample_q <= Din;
                end
                // count_q equals the 0-based index of the sample under test here.
                CMP_MAX: begin
                    if (upd_max) begin
                        Max     <= sample_q;
`ifdef CMP_ARGIDX_EN
                        Max_idx <= count_q;
`endif
                    end
                end
                CMP_MIN: begin
                    if (upd_min) begin
                        Min     <= sample_q;
`ifdef CMP_ARGIDX_EN
                        Min_idx <= count_q;
`endif
                    end
                    count_q <= count_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cmp_minmax_seq.sv
// Directed bench for cmp_minmax_seq: an 8-sample instance plus a 1-sample instance.
// Builds with or without CMP_ARGIDX_EN.

module tb_cmp_minmax_seq;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    // 8-sample instance
    logic       Start = 1'b0;
    logic [3:0] Din = 4'd0;
    logic       Din_valid = 1'b0;
    logic       Din_ready;
    logic [3:0] Max, Min;
    logic       Busy, Done;
    logic [2:0] state_dbg;
`ifdef CMP_ARGIDX_EN
    logic [3:0] Max_idx, Min_idx;
`endif

    // 1-sample instance
    logic       s_start = 1'b0;
    logic [3:0] s_din = 4'd0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [3:0] s_max, s_min;
    logic       s_busy, s_done;
    logic [2:0] s_state;
`ifdef CMP_ARGIDX_EN
    logic [0:0] s_max_idx, s_min_idx;
`endif

    cmp_minmax_seq #(.N_SAMPLES(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Start     (Start),
        .Din       (Din),
        .Din_valid (Din_valid),
        .Din_ready (Din_ready),
        .Max       (Max),
        .Min       (Min),
        .Busy      (Busy),
        .Done      (Done),
        .state_dbg (state_dbg)
`ifdef CMP_ARGIDX_EN
        ,
        .Max_idx   (Max_idx),
        .Min_idx   (Min_idx)
`endif
    );

    cmp_minmax_seq #(.N_SAMPLES(1)) dut1 (
        .CLK       (CLK),
        .RST       (RST),
        .Start     (s_start),
        .Din       (s_din),
        .Din_valid (s_valid),
        .Din_ready (s_ready),
        .Max       (s_max),
        .Min       (s_min),
        .Busy      (s_busy),
        .Done      (s_done),
        .state_dbg (s_state)
`ifdef CMP_ARGIDX_EN
        ,
        .Max_idx   (s_max_idx),
        .Min_idx   (s_min_idx)
`endif
    );

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CMP_MAX = 3'd3;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int res_lat, res_hs, res_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Runs one burst; inputs change 1 time unit after each rising edge.
    // glitch=1 pulses Start in every CMP_MAX cycle and in the DONE cycle.
    task automatic run_burst(input logic [3:0] v [8], input bit rand_valid,
                             input int stop_after, input bit glitch);
        int idx;
        int cyc;
        idx = 0;
        res_hs = 0;
        res_done = 0;
        res_lat = -1;
        Start = 1'b1;
        Din_valid = 1'b0;
        tick();
        Start = 1'b0;
        cyc = 1;
        while (cyc < 300) begin
            if (stop_after > 0 && res_hs == stop_after) return;
            Din_valid = (idx < 8) && (rand_valid ? 1'($urandom_range(0, 1)) : 1'b1);
            Din = Din_ready ? v[(idx < 8) ? idx : 0] : 4'($urandom_range(0, 15));
            Start = glitch && (state_dbg == ST_CMP_MAX);
            if (Din_ready && Din_valid) begin
                res_hs++;
                idx++;
            end
            tick();
            cyc++;
            if (Done) begin
                res_done++;
                res_lat = cyc;
                break;
            end
        end
        Start = glitch;
        Din_valid = 1'b0;
        tick();
        Start = 1'b0;
        if (Done) res_done++;
    endtask

    logic [3:0] vec_a [8];
    logic [3:0] vec_b [8];
    logic [3:0] vec_c [8];

    initial begin
        vec_a = '{4'd3, 4'd9, 4'd1, 4'd15, 4'd0, 4'd7, 4'd7, 4'd2};
        vec_b = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
        vec_c = '{4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd1};

        // Reset held for two cycles
        tick();
        tick();
        check("rst_max", Max, 0);
        check("rst_min", Min, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_ready", Din_ready, 0);
        RST = 1'b0;
        tick();
        tick();
        check("post_rst_state", state_dbg, ST_IDLE);
        check("post_rst_busy", Busy, 0);

        // Continuous-valid burst
        run_burst(vec_a, 1'b0, 0, 1'b0);
        check("a_max", Max, 15);
        check("a_min", Min, 0);
        check("a_latency", res_lat, 23);
        check("a_done_pulses", res_done, 1);
        check("a_handshakes", res_hs, 8);
        check("a_idle", state_dbg, ST_IDLE);
`ifdef CMP_ARGIDX_EN
        check("a_max_idx", Max_idx, 3);
        check("a_min_idx", Min_idx, 4);
`endif

        // All-equal burst: ties never update
        run_burst(vec_b, 1'b0, 0, 1'b0);
        check("b_max", Max, 5);
        check("b_min", Min, 5);
        check("b_done_pulses", res_done, 1);
`ifdef CMP_ARGIDX_EN
        check("b_max_idx", Max_idx, 0);
        check("b_min_idx", Min_idx, 0);
`endif

        // Random valid with garbage data while not ready
        run_burst(vec_a, 1'b1, 0, 1'b0);
        check("r_max", Max, 15);
        check("r_min", Min, 0);
        check("r_handshakes", res_hs, 8);
        check("r_done_pulses", res_done, 1);
        check("r_timeout", (res_lat > 0), 1);
`ifdef CMP_ARGIDX_EN
        check("r_max_idx", Max_idx, 3);
        check("r_min_idx", Min_idx, 4);
`endif

        // Asynchronous reset in the middle of a burst
        run_burst(vec_a, 1'b0, 3, 1'b0);
        check("mid_busy_before", Busy, 1);
        Din_valid = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        check("mid_rst_max", Max, 0);
        check("mid_rst_min", Min, 0);
        check("mid_rst_busy", Busy, 0);
        check("mid_rst_ready", Din_ready, 0);
        check("mid_rst_state", state_dbg, ST_IDLE);
        tick();
        RST = 1'b0;
        tick();
        run_burst(vec_c, 1'b0, 0, 1'b0);
        check("c_max", Max, 8);
        check("c_min", Min, 1);
        check("c_latency", res_lat, 23);
`ifdef CMP_ARGIDX_EN
        check("c_max_idx", Max_idx, 0);
        check("c_min_idx", Min_idx, 7);
`endif

        // Start pulsed in CMP_MAX and in the DONE cycle is ignored
        run_burst(vec_a, 1'b0, 0, 1'b1);
        check("g_max", Max, 15);
        check("g_min", Min, 0);
        check("g_latency", res_lat, 23);
        check("g_done_pulses", res_done, 1);
        check("g_no_restart", state_dbg, ST_IDLE);
        tick();
        check("g_still_idle", state_dbg, ST_IDLE);
        check("g_busy", Busy, 0);

        // Single-sample instance
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("s1_ready", s_ready, 1);
        check("s1_done_early", s_done, 0);
        s_valid = 1'b1;
        s_din = 4'd6;
        tick();
        s_valid = 1'b0;
        check("s1_done", s_done, 1);
        check("s1_max", s_max, 6);
        check("s1_min", s_min, 6);
        tick();
        check("s1_done_pulse", s_done, 0);
        check("s1_busy", s_busy, 0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cmp_minmax_seq.md
Name: cmp_minmax_seq

Overview:
Sequential min/max finder built around one shared instance of the team's 4-bit dataflow comparator, comparator_4_df1 (Eq/Gt/St outputs).
- Accepts a burst of N_SAMPLES 4-bit values over a valid/ready handshake.
- Time-multiplexes the comparator between the running-max and running-min checks.
- Reports the final Max/Min with a one-cycle Done pulse.
- Sits between a sample source and any consumer needing burst extremes; the first controller in the codebase that sequences the comparator.

Parameters:
N_SAMPLES, 8, samples per burst; legal range 1..255.
CNT_W, $clog2(N_SAMPLES+1), sample-counter width; derived, not to be overridden.

Ports:
CLK  input  1  rising-edge clock.
RST  input  1  asynchronous, active-high reset.
Start  input  1  begin a burst; sampled only in IDLE.
Din  input  4  sample data.
Din_valid  input  1  Din holds a sample.
Din_ready  output  1  block will capture Din this cycle if Din_valid=1.
Max  output  4  running/final maximum.
Min  output  4  running/final minimum.
Busy  output  1  burst in progress.
Done  output  1  one-cycle pulse; Max/Min are final.

Behaviour:
- Reset (async, any state): state=IDLE; Max=0, Min=0, sample reg=0, count=0, Busy=0, Done=0, Din_ready=0.
- FSM states: IDLE, LOAD, WAIT_IN, CMP_MAX, CMP_MIN, DONE.
- IDLE: Busy=0. Start=1 -> LOAD next cycle; Max/Min keep previous burst results until first sample loads.
- LOAD: Din_ready=1, Busy=1. On Din_valid: Max<=Din, Min<=Din, count<=1.
  - If N_SAMPLES==1 -> DONE; else -> WAIT_IN.
  - No valid -> stay in LOAD.
- WAIT_IN: Din_ready=1. On Din_valid: sample reg<=Din -> CMP_MAX; else stay.
- CMP_MAX: comparator A=sample, B=Max; if Gt then Max<=sample -> CMP_MIN.
- CMP_MIN: comparator A=sample, B=Min; if St then Min<=sample; count<=count+1.
  - If count+1==N_SAMPLES -> DONE; else -> WAIT_IN.
- DONE: Done=1, Busy=0 for exactly one cycle -> IDLE; Max/Min hold until the next LOAD capture.
- Din_ready is 0 in IDLE, CMP_MAX, CMP_MIN and DONE. Din/Din_valid there are ignored and not counted.
- Comparator muxes: A is always the sample reg; B selects Max in CMP_MAX and Min in CMP_MIN (don't-care elsewhere). A single comparator instance is used.
- Ties: only strict Gt/St update, so equal values never modify Max/Min.
- Throughput: 3 cycles per sample after the first with Din_valid held high.
- Latency with continuous valid: Done is asserted 2+3*(N_SAMPLES-1) cycles after the cycle Start is sampled in IDLE.
- Start outside IDLE (including in the DONE cycle) is ignored; no restart or abort.
- Unsigned 4-bit compares; count never wraps (max N_SAMPLES=255 fits CNT_W).

Optional Feature:
Macro CMP_ARGIDX_EN.
- Defined: adds outputs Max_idx and Min_idx, each CNT_W wide, giving the 0-based sample index of the current Max/Min.
  - LOAD sets both to 0.
  - Updated on the same Gt/St condition as Max/Min, so ties keep the first occurrence.
  - Reset value 0.
- Undefined: ports and index registers are absent; all other behaviour is identical.

Test Plan:
- Assert RST for 2 cycles -> Max=0, Min=0, Busy=0, Done=0, Din_ready=0; release -> state stays IDLE.
- N_SAMPLES=8, Start, continuous valid with 3,9,1,15,0,7,7,2 -> Max=15, Min=0, Done high exactly 1 cycle, 23 cycles after Start sampled; with CMP_ARGIDX_EN, Max_idx=3, Min_idx=4.
- N_SAMPLES=8, all samples 5 -> Max=5, Min=5; with CMP_ARGIDX_EN, Max_idx=0, Min_idx=0 (tie keeps first).
- Din_valid toggled randomly, with garbage Din driven while Din_ready=0 -> same results as continuous case; exactly 8 handshakes counted.
- RST pulsed after 3 accepted samples -> immediate IDLE with all outputs 0; a new Start with 8,8,8,8,8,8,8,1 -> Max=8, Min=1.
- Start pulsed during CMP_MAX and in the DONE cycle -> ignored, no second burst; N_SAMPLES=1 build with Din=6 -> Max=Min=6, Done 2 cycles after Start.
